sad_accumulator: RTL and testbench
==================================

# sad_accumulator

Computes the five candidate SADs that feed the minimum-SAD selector in the motion-estimation datapath. It streams one current-block pixel and five co-located reference pixels per accepted cycle over an 8x8 block (64 pixels). It accumulates |cur − ref_k| per candidate and presents the packed 70-bit SAD vector with a one-cycle valid pulse. The vector layout matches the selector's input exactly: candidate k occupies bits [14k+13:14k].

## Interface
- PIX_W, 8, pixel width
- N_PIX, 64, pixels per block
- SAD_W, 14, accumulator/field width; N_PIX·(2^PIX_W−1) must fit in SAD_W bits
- N_CAND, 5, candidate count (fixed at 5 for selector compatibility)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin new block: clears accumulators and pixel counter
- pix_valid  in  1  cur_pix/ref_pix valid this cycle
- cur_pix  in  PIX_W  current-block pixel
- ref_pix  in  N_CAND·PIX_W  candidate k pixel at [8k+7:8k]
- ready  out  1  pixels accepted this cycle (high only in ACCUM)
- sad_vec  out  N_CAND·SAD_W  packed SADs, candidate k at [14k+13:14k]
- sad_valid  out  1  one-cycle pulse, sad_vec final
- busy  out  1  high in ACCUM, DRAIN and DONE

## Operation
- FSM states:
  - IDLE: waits for start.
  - ACCUM: accepts pixels.
  - DRAIN: one cycle; the last difference enters the accumulators.
  - DONE: one cycle; sad_valid=1. Returns to IDLE.
- start, sampled in any state: moves to ACCUM next cycle. Zeroes the accumulators, the 7-bit pixel count and the stage-1 valid bit, so in-flight data is discarded. The pixel presented in the start cycle is ignored.
- Accepted pixel: pix_valid && state==ACCUM. pix_valid outside ACCUM is ignored.
- Stage 1 registers five absolute differences. Compute each as an unsigned PIX_W-bit value: cur ≥ ref ? cur−ref : ref−cur. A stage-1 valid bit is registered alongside.
- Stage 2: when the stage-1 valid bit is set, acc_k += diff_k. The diff is zero-extended to SAD_W. The adder saturates at all-ones; it cannot overflow with the defaults.
- The 64th accepted pixel moves the FSM ACCUM→DRAIN. Any further pix_valid is ignored.
- sad_vec is driven directly from the accumulators. It holds its value through DONE and IDLE until the next start or rst.
- Gaps in pix_valid during ACCUM are allowed and do not affect the result.

## Timing
- Reset: state IDLE, ready=0, busy=0, sad_valid=0, sad_vec=0, count=0, stage-1 valid=0.
- rst takes priority over start, including mid-block. rst mid-block produces no sad_valid.
- start in cycle c: ready=1 from c+1.
- Last (64th) pixel accepted in cycle c:
  - ready=0 from c+1 (DRAIN).
  - sad_valid=1 in c+2 only (DONE), with final sad_vec.
  - busy=0 from c+3.
- Minimum block time, contiguous pixels: start, plus 64 accept cycles, plus 2 = 67 cycles from start to sad_valid inclusive.
- start in the DONE cycle: sad_valid still pulses that cycle. Accumulators clear the next cycle and the FSM enters ACCUM.
- start during DRAIN: aborts; no sad_valid.

## Test plan
- Reset, then idle 10 cycles with pix_valid=1 → ready=0, busy=0, sad_valid=0, sad_vec=0 throughout.
- start, then 64 contiguous pixels with cur=100, ref_k=100+k → sad_valid exactly 2 cycles after the last accept. Fields = 0, 64, 128, 192, 256; sad_vec stable afterwards in IDLE.
- Extremes: cur=0, all ref=255, 64 pixels → every field 16320 (0x3FC0). Repeat with cur=255, ref=0 → same; proves absolute value and no overflow.
- pix_valid toggling every other cycle, cur=200, ref_k=50 → every field 9600. ready stays high through gaps; sad_valid 2 cycles after the 64th accept.
- Restart: 30 pixels with diff 10, then start with pix_valid=1 in the same cycle, then 64 pixels with diff 1 → every field 64. The start-cycle pixel is not counted.
- rst asserted after 40 pixels → next cycle all outputs 0 and state IDLE. No sad_valid appears over the following 70 cycles of pix_valid=1 without start.

Source files
------------

// File: rtl/sad_accumulator.sv
// Five-candidate SAD accumulator for an 8x8 block; feeds the minimum-SAD selector.
// Stage 1 registers |cur - ref_k|, stage 2 adds it into a saturating accumulator.
module sad_accumulator #(
    parameter int PIX_W  = 8,
    parameter int N_PIX  = 64,
    parameter int SAD_W  = 14,
    parameter int N_CAND = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      pix_valid,
    input  logic [PIX_W-1:0]          cur_pix,
    input  logic [N_CAND*PIX_W-1:0]   ref_pix,
    output logic                      ready,
    output logic [N_CAND*SAD_W-1:0]   sad_vec,
    output logic                      sad_valid,
    output logic                      busy
);

    localparam int CNT_W = $clog2(N_PIX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count;
    logic               s1_valid;
    logic               accept;
    logic               last_pix;
    logic [PIX_W-1:0]   diff_d   [N_CAND];
    logic [PIX_W-1:0]   diff_q   [N_CAND];
    logic [SAD_W-1:0]   acc      [N_CAND];
    logic [SAD_W-1:0]   acc_sum  [N_CAND];
    logic [SAD_W:0]     acc_wide [N_CAND];

    assign accept   = pix_valid && (state == ACCUM);
    assign last_pix = accept && (count == CNT_W'(N_PIX - 1));

    always_comb begin
        for (int k = 0; k < N_CAND; k++) begin
            diff_d[k] = '0;
            if (cur_pix >= ref_pix[k*PIX_W +: PIX_W])
                diff_d[k] = cur_pix - ref_pix[k*PIX_W +: PIX_W];
            else
                diff_d[k] = ref_pix[k*PIX_W +: PIX_W] - cur_pix;
        end
    end

    // Carry out of the widened sum clamps the field to all-ones.
    always_comb begin
        for (int k = 0; k < N_CAND; k++) begin
            acc_wide[k] = {1'b0, acc[k]} + (SAD_W + 1)'(diff_q[k]);
            acc_sum[k]  = acc_wide[k][SAD_W] ? '1 : acc_wide[k][SAD_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ACCUM;
        end else begin
            unique case (state)
                IDLE:    state_nxt = IDLE;
                ACCUM:   state_nxt = last_pix ? DRAIN : ACCUM;
                DRAIN:   state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b0;
            busy      <= 1'b0;
            sad_valid <= 1'b0;
            count     <= '0;
            s1_valid  <= 1'b0;
            acc       <= '{default: '0};
            diff_q    <= '{default: '0};
        end else begin
            state     <= state_nxt;
            ready     <= (state_nxt == ACCUM);
            busy      <= (state_nxt != IDLE);
            sad_valid <= (state_nxt == DONE);
            if (start) begin
                count    <= '0;
                s1_valid <= 1'b0;
                acc      <= '{default: '0};
            end else begin
                s1_valid <= accept;
                if (accept)
                    count <= count + CNT_W'(1);
                if (s1_valid)
                    acc <= acc_sum;
            end
            if (accept)
                diff_q <= diff_d;
        end
    end

    for (genvar k = 0; k < N_CAND; k++) begin : g_pack
        assign sad_vec[k*SAD_W +: SAD_W] = acc[k];
    end

endmodule

// File: tb/tb_sad_accumulator.sv
// Randomised and directed bench for sad_accumulator against a cycle-level
// model built from block-level rules (accept count, drain tail, running sums).
module tb_sad_accumulator;

    localparam int PIX_W  = 8;
    localparam int N_PIX  = 64;
    localparam int SAD_W  = 14;
    localparam int N_CAND = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  cur_pix = '0;
    logic [39:0] ref_pix = '0;
    logic        ready;
    logic        sad_valid;
    logic        busy;
    logic [69:0] sad_vec;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sad_accumulator #(
        .PIX_W (PIX_W),
        .N_PIX (N_PIX),
        .SAD_W (SAD_W),
        .N_CAND(N_CAND)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pix_valid(pix_valid),
        .cur_pix  (cur_pix),
        .ref_pix  (ref_pix),
        .ready    (ready),
        .sad_vec  (sad_vec),
        .sad_valid(sad_valid),
        .busy     (busy)
    );

    // Model: m_n = pixels accepted in the open block (-1 = none open),
    // m_tail = cycles since the 64th accept (1 drain, 2 result cycle).
    // vis = sums visible on sad_vec, pend = difference still in flight.
    int m_n = -1;
    int m_tail = 0;
    int vis [N_CAND];
    int pend [N_CAND];
    bit chk_en = 1'b0;
    int cyc = 0;
    int last_valid_cyc = -1;

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic logic [39:0] pack_refs(input int base, input int inc);
        logic [39:0] r;
        for (int k = 0; k < N_CAND; k++)
            r[k*8 +: 8] = 8'(base + inc * k);
        return r;
    endfunction

    function automatic logic [39:0] rand40();
        return {8'($urandom), 32'($urandom)};
    endfunction

    task automatic chk(input string nm, input logic [69:0] act,
                       input logic [69:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        bit acc_now;
        cyc++;
        acc_now = (m_n >= 0) && (m_n < N_PIX) && (pix_valid === 1'b1);
        if (rst) begin
            chk_en = 1'b1;
            m_n = -1;
            m_tail = 0;
            for (int k = 0; k < N_CAND; k++) begin
                vis[k] = 0;
                pend[k] = 0;
            end
        end else if (start) begin
            m_n = 0;
            m_tail = 0;
            for (int k = 0; k < N_CAND; k++) begin
                vis[k] = 0;
                pend[k] = 0;
            end
        end else begin
            for (int k = 0; k < N_CAND; k++) begin
                vis[k] += pend[k];
                pend[k] = acc_now ?
                    absdiff(int'(cur_pix), int'(ref_pix[k*8 +: 8])) : 0;
            end
            if (m_tail == 2) begin
                m_tail = 0;
                m_n = -1;
            end else if (m_tail == 1) begin
                m_tail = 2;
            end
            if (acc_now) begin
                m_n++;
                if (m_n == N_PIX)
                    m_tail = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [69:0] e_vec;
        bit e_ready;
        if (chk_en) begin
            for (int k = 0; k < N_CAND; k++)
                e_vec[k*SAD_W +: SAD_W] = 14'(vis[k]);
            e_ready = (m_n >= 0) && (m_n < N_PIX);
            chk("ready", 70'(ready), 70'(e_ready));
            chk("busy", 70'(busy), 70'(e_ready || (m_tail != 0)));
            chk("sad_valid", 70'(sad_valid), 70'(m_tail == 2));
            chk("sad_vec", sad_vec, e_vec);
            if (sad_valid === 1'b1)
                last_valid_cyc = cyc;
        end
    end

    task automatic step(input bit st, input bit pv, input logic [7:0] c,
                        input logic [39:0] r);
        start = st;
        pix_valid = pv;
        cur_pix = c;
        ref_pix = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fields(input string nm, input int f0, input int fstep);
        for (int k = 0; k < N_CAND; k++) begin
            chk({nm, "_dut"}, 70'(sad_vec[k*SAD_W +: SAD_W]),
                70'(f0 + fstep * k));
            chk({nm, "_model"}, 70'(vis[k]), 70'(f0 + fstep * k));
        end
    endtask

    task automatic block(input logic [7:0] c, input logic [39:0] r);
        step(1'b1, 1'b0, 8'd0, 40'd0);
        repeat (N_PIX) step(1'b0, 1'b1, c, r);
        repeat (5) step(1'b0, 1'b0, 8'd0, 40'd0);
    endtask

    initial begin
        int sc;
        rst = 1'b1;
        step(1'b0, 1'b0, 8'd0, 40'd0);
        step(1'b0, 1'b0, 8'd0, 40'd0);
        rst = 1'b0;
        repeat (10) step(1'b0, 1'b1, 8'($urandom), rand40());
        chk_fields("idle", 0, 0);

        sc = cyc;
        block(8'd100, pack_refs(100, 1));
        chk_fields("ramp", 0, 64);
        chk("block_cycles", 70'(last_valid_cyc - sc + 1), 70'(67));

        block(8'd0, pack_refs(255, 0));
        chk_fields("ext_lo", 16320, 0);
        block(8'd255, pack_refs(0, 0));
        chk_fields("ext_hi", 16320, 0);

        step(1'b1, 1'b0, 8'd0, 40'd0);
        for (int i = 0; i < 2 * N_PIX; i++)
            step(1'b0, (i % 2) == 0, 8'd200, pack_refs(50, 0));
        repeat (4) step(1'b0, 1'b0, 8'd0, 40'd0);
        chk_fields("gaps", 9600, 0);

        step(1'b1, 1'b0, 8'd0, 40'd0);
        repeat (30) step(1'b0, 1'b1, 8'd20, pack_refs(10, 0));
        step(1'b1, 1'b1, 8'd20, pack_refs(10, 0));
        repeat (N_PIX) step(1'b0, 1'b1, 8'd11, pack_refs(10, 0));
        repeat (4) step(1'b0, 1'b0, 8'd0, 40'd0);
        chk_fields("restart", 64, 0);

        step(1'b1, 1'b0, 8'd0, 40'd0);
        repeat (40) step(1'b0, 1'b1, 8'($urandom), rand40());
        sc = last_valid_cyc;
        rst = 1'b1;
        step(1'b0, 1'b1, 8'($urandom), rand40());
        rst = 1'b0;
        repeat (70) step(1'b0, 1'b1, 8'($urandom), rand40());
        chk_fields("after_rst", 0, 0);
        chk("no_valid_after_rst", 70'(last_valid_cyc), 70'(sc));

        for (int b = 0; b < 8; b++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), rand40());
            for (int i = 0; i < 110; i++) begin
                rst = ($urandom_range(0, 399) == 0);
                step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                     8'($urandom), rand40());
                rst = 1'b0;
            end
            repeat (5) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom),
                            rand40());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
